// File: rtl/array_18_ctrl.sv
// Sequencing controller for a single-port masked SRAM: zero-fill after reset/clr,
// round-robin read/write arbitration, one-entry registered read response buffer.
module array_18_ctrl #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int WIDTH  = 1316,
    parameter int SEGS   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_init_done,
    input  logic              i_rd_req_valid,
    output logic              o_rd_req_ready,
    input  logic [ADDR_W-1:0] i_rd_req_addr,
    output logic              o_rd_resp_valid,
    input  logic              i_rd_resp_ready,
    output logic [WIDTH-1:0]  o_rd_resp_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [SEGS-1:0]   i_wr_mask,
    input  logic [WIDTH-1:0]  i_wr_data,
    output logic              o_sram_en,
    output logic              o_sram_wmode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [SEGS-1:0]   o_sram_wmask,
    output logic [WIDTH-1:0]  o_sram_wdata,
    input  logic [WIDTH-1:0]  i_sram_rdata
);

    typedef enum logic [1:0] {ST_BOOT, ST_INIT, ST_IDLE} state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_init_ctr;
    logic               r_p1;
    logic               r_last_wr;
    logic               r_resp_valid;
    logic [WIDTH-1:0]   r_resp_data;

    logic w_act, w_rd_elig, w_rd_wins, w_rd_gnt, w_wr_gnt, w_init_last;

    // clr in IDLE blocks all grants for that cycle
    assign w_act       = (r_state == ST_IDLE) && !i_clr;
    assign w_rd_elig   = w_act && !r_p1 && (!r_resp_valid || i_rd_resp_ready);
    assign w_rd_wins   = r_last_wr;
    assign w_init_last = (r_init_ctr == ADDR_W'(DEPTH-1));

    assign o_rd_req_ready  = w_rd_elig && (!i_wr_valid || w_rd_wins);
    assign o_wr_ready      = w_act && !(w_rd_elig && i_rd_req_valid && w_rd_wins);
    assign w_rd_gnt        = o_rd_req_ready && i_rd_req_valid;
    assign w_wr_gnt        = o_wr_ready && i_wr_valid;
    assign o_rd_resp_valid = r_resp_valid;
    assign o_rd_resp_data  = r_resp_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_BOOT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_init_done  = 1'b0;
        o_sram_en    = 1'b0;
        o_sram_wmode = 1'b0;
        o_sram_addr  = '0;
        o_sram_wmask = '0;
        o_sram_wdata = '0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_INIT;
            ST_INIT: begin
                o_sram_en    = 1'b1;
                o_sram_wmode = 1'b1;
                o_sram_addr  = r_init_ctr;
                o_sram_wmask = '1;
                if (w_init_last) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                o_init_done = 1'b1;
                if (i_clr) w_state_nxt = ST_INIT;
                if (w_wr_gnt) begin
                    o_sram_en    = 1'b1;
                    o_sram_wmode = 1'b1;
                    o_sram_addr  = i_wr_addr;
                    o_sram_wmask = i_wr_mask;
                    o_sram_wdata = i_wr_data;
                end else if (w_rd_gnt) begin
                    o_sram_en   = 1'b1;
                    o_sram_addr = i_rd_req_addr;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Counter idles at zero outside INIT, so every entry into INIT starts at address 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_init_ctr <= '0;
        else if (r_state == ST_INIT) r_init_ctr <= r_init_ctr + 1'b1;
        else                         r_init_ctr <= '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p1      <= 1'b0;
            r_last_wr <= 1'b0;
        end else begin
            r_p1 <= w_rd_gnt;
            if (w_rd_gnt || w_wr_gnt) r_last_wr <= w_wr_gnt;
        end
    end

    // A load wins over a same-cycle pop, keeping the buffer full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else if (r_p1) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= i_sram_rdata;
        end else if (r_resp_valid && i_rd_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_array_18_ctrl.sv
// Directed bench for array_18_ctrl with a behavioural masked SRAM attached to the macro port.
module tb_array_18_ctrl;
    localparam int DEPTH = 128, ADDR_W = 7, WIDTH = 1316, SEGS = 4, SEG_W = WIDTH / SEGS;

    logic              i_clk = 1'b0, i_rst_n = 1'b0, i_clr = 1'b0;
    logic              o_init_done;
    logic              i_rd_req_valid = 1'b0, o_rd_req_ready;
    logic [ADDR_W-1:0] i_rd_req_addr = '0;
    logic              o_rd_resp_valid, i_rd_resp_ready = 1'b1;
    logic [WIDTH-1:0]  o_rd_resp_data;
    logic              i_wr_valid = 1'b0, o_wr_ready;
    logic [ADDR_W-1:0] i_wr_addr = '0;
    logic [SEGS-1:0]   i_wr_mask = '0;
    logic [WIDTH-1:0]  i_wr_data = '0;
    logic              o_sram_en, o_sram_wmode;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [SEGS-1:0]   o_sram_wmask;
    logic [WIDTH-1:0]  o_sram_wdata, i_sram_rdata;

    int checks = 0, errors = 0;

    array_18_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .SEGS(SEGS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .o_init_done(o_init_done),
        .i_rd_req_valid(i_rd_req_valid), .o_rd_req_ready(o_rd_req_ready), .i_rd_req_addr(i_rd_req_addr),
        .o_rd_resp_valid(o_rd_resp_valid), .i_rd_resp_ready(i_rd_resp_ready), .o_rd_resp_data(o_rd_resp_data),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_mask(i_wr_mask),
        .i_wr_data(i_wr_data), .o_sram_en(o_sram_en), .o_sram_wmode(o_sram_wmode), .o_sram_addr(o_sram_addr),
        .o_sram_wmask(o_sram_wmask), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata));

    always #5 i_clk = ~i_clk;

    // Macro model: masked write commits at the edge, read data valid the next cycle
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge i_clk) begin
        if (o_sram_en) begin
            if (o_sram_wmode) begin
                for (int s = 0; s < SEGS; s++)
                    if (o_sram_wmask[s]) mem[o_sram_addr][s*SEG_W +: SEG_W] <= o_sram_wdata[s*SEG_W +: SEG_W];
            end else begin
                i_sram_rdata <= mem[o_sram_addr];
            end
        end
    end

    function automatic logic [WIDTH-1:0] mk(input logic [31:0] s);
        logic [42*32-1:0] t;
        t = {42{s}};
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] segs(input logic [SEGS-1:0] m);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int s = 0; s < SEGS; s++) if (m[s]) r[s*SEG_W +: SEG_W] = '1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        logic [31:0] a_lo, e_lo, a_hi, e_hi;
        a_lo = act[31:0]; e_lo = exp[31:0]; a_hi = act[WIDTH-1:WIDTH-32]; e_hi = exp[WIDTH-1:WIDTH-32];
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual lo/hi=%h/%h required lo/hi=%h/%h", nm, a_lo, a_hi, e_lo, e_hi);
        end
    endtask

    task automatic idle_in();
        i_rd_req_valid = 1'b0; i_wr_valid = 1'b0; i_clr = 1'b0; i_rd_resp_ready = 1'b1;
        i_wr_mask = '0; i_wr_data = '0; i_wr_addr = '0; i_rd_req_addr = '0;
    endtask

    // Called in the phase before the first INIT edge; checks 128 zero-fill writes, then IDLE
    task automatic init_run(input bit chk_resp, input logic [WIDTH-1:0] exp_d);
        int nwr;
        nwr = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge i_clk); idle_in(); #1;
            if (o_sram_en && o_sram_wmode && o_sram_addr == ADDR_W'(k) && o_sram_wmask == 4'hF &&
                o_sram_wdata == '0 && !o_init_done && !o_rd_req_ready && !o_wr_ready) nwr++;
            if (k == 0 && chk_resp) begin
                chk("resp_valid_during_init", o_rd_resp_valid, 1);
                chkd("resp_data_pre_clear", o_rd_resp_data, exp_d);
            end
        end
        chk("init_writes", nwr, DEPTH);
        @(negedge i_clk); #1;
        chk("init_done_after_init", o_init_done, 1);
        chk("idle_en_low", o_sram_en, 0);
    endtask

    task automatic init_boot();
        chk("boot_en", o_sram_en, 0);
        chk("boot_init_done", o_init_done, 0);
        init_run(1'b0, '0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp_d);
        int n;
        @(negedge i_clk); idle_in(); i_rd_req_valid = 1'b1; i_rd_req_addr = a; #1;
        n = 0;
        while (!o_rd_req_ready && n < 20) begin @(negedge i_clk); #1; n++; end
        chk("rd_accept", o_rd_req_ready, 1);
        @(negedge i_clk); idle_in(); #1;
        chk("rd_lat_n1", o_rd_resp_valid, 0);
        @(negedge i_clk); #1;
        chk("rd_lat_n2", o_rd_resp_valid, 1);
        chkd("rd_data", o_rd_resp_data, exp_d);
    endtask

    typedef struct {
        logic rv; logic [ADDR_W-1:0] ra; logic rr;
        logic wv; logic [ADDR_W-1:0] wa; logic [SEGS-1:0] wm; logic [31:0] ws;
        logic e_rrdy, e_wrdy, e_en, e_wmode; logic [ADDR_W-1:0] e_addr; logic [SEGS-1:0] e_mask;
        logic e_rv; logic [WIDTH-1:0] e_d;
    } vec_t;

    function automatic vec_t V(bit rv, int ra, bit rr, bit wv, int wa, logic [3:0] wm, logic [31:0] ws,
                               bit err, bit ewr, bit een, bit ewm, int ea, logic [3:0] em,
                               bit erv, logic [WIDTH-1:0] ed);
        vec_t v;
        v.rv = rv; v.ra = ADDR_W'(ra); v.rr = rr; v.wv = wv; v.wa = ADDR_W'(wa); v.wm = wm; v.ws = ws;
        v.e_rrdy = err; v.e_wrdy = ewr; v.e_en = een; v.e_wmode = ewm; v.e_addr = ADDR_W'(ea);
        v.e_mask = em; v.e_rv = erv; v.e_d = ed;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=expired required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //          rv ra rr  wv wa  wm       ws            rrdy wrdy en wm addr mask  rv data
        tbl[0]  = V(0, 0, 1,  1, 3, 4'b0101, 32'hFFFFFFFF, 0, 1, 1, 1, 3, 4'b0101, 0, '0);
        tbl[1]  = V(1, 3, 1,  0, 0, 4'h0, 0,               1, 0, 1, 0, 3, 4'h0, 0, '0);
        tbl[2]  = V(0, 0, 1,  0, 0, 4'h0, 0,               0, 1, 0, 0, 0, 4'h0, 0, '0);
        tbl[3]  = V(0, 0, 1,  0, 0, 4'h0, 0,               1, 1, 0, 0, 0, 4'h0, 1, segs(4'b0101));
        tbl[4]  = V(1, 3, 1,  1, 10, 4'hF, 32'h11111111,   0, 1, 1, 1, 10, 4'hF, 0, '0);
        tbl[5]  = V(1, 10, 1, 1, 11, 4'hF, 32'h22222222,   1, 0, 1, 0, 10, 4'h0, 0, '0);
        tbl[6]  = V(1, 10, 1, 1, 11, 4'hF, 32'h22222222,   0, 1, 1, 1, 11, 4'hF, 0, '0);
        tbl[7]  = V(1, 11, 1, 1, 12, 4'hF, 32'h33333333,   1, 0, 1, 0, 11, 4'h0, 1, mk(32'h11111111));
        tbl[8]  = V(1, 11, 1, 1, 12, 4'hF, 32'h33333333,   0, 1, 1, 1, 12, 4'hF, 0, '0);
        tbl[9]  = V(1, 12, 0, 0, 0, 4'h0, 0,               0, 1, 0, 0, 0, 4'h0, 1, mk(32'h22222222));
        tbl[10] = V(1, 12, 0, 0, 0, 4'h0, 0,               0, 1, 0, 0, 0, 4'h0, 1, mk(32'h22222222));
        tbl[11] = V(1, 12, 1, 0, 0, 4'h0, 0,               1, 0, 1, 0, 12, 4'h0, 1, mk(32'h22222222));
        tbl[12] = V(0, 0, 1,  0, 0, 4'h0, 0,               0, 1, 0, 0, 0, 4'h0, 0, '0);
        tbl[13] = V(0, 0, 1,  0, 0, 4'h0, 0,               1, 1, 0, 0, 0, 4'h0, 1, mk(32'h33333333));
        tbl[14] = V(0, 0, 1,  1, 12, 4'h0, 32'hFFFFFFFF,   0, 1, 1, 1, 12, 4'h0, 0, '0);
        tbl[15] = V(1, 12, 1, 0, 0, 4'h0, 0,               1, 0, 1, 0, 12, 4'h0, 0, '0);
        tbl[16] = V(0, 0, 1,  0, 0, 4'h0, 0,               0, 1, 0, 0, 0, 4'h0, 0, '0);
        tbl[17] = V(0, 0, 1,  0, 0, 4'h0, 0,               1, 1, 0, 0, 0, 4'h0, 1, mk(32'h33333333));
        tbl[18] = V(1, 20, 1, 0, 0, 4'h0, 0,               1, 1, 1, 0, 20, 4'h0, 0, '0);
        tbl[19] = V(0, 0, 1,  1, 20, 4'hF, 32'h55555555,   0, 1, 1, 1, 20, 4'hF, 0, '0);
        tbl[20] = V(0, 0, 1,  0, 0, 4'h0, 0,               1, 1, 0, 0, 0, 4'h0, 1, '0);
        tbl[21] = V(1, 20, 1, 0, 0, 4'h0, 0,               1, 0, 1, 0, 20, 4'h0, 0, '0);
        tbl[22] = V(0, 0, 1,  0, 0, 4'h0, 0,               0, 1, 0, 0, 0, 4'h0, 0, '0);
        tbl[23] = V(0, 0, 1,  0, 0, 4'h0, 0,               1, 1, 0, 0, 0, 4'h0, 1, mk(32'h55555555));

        idle_in();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_en", o_sram_en, 0);
        chk("rst_init_done", o_init_done, 0);
        chk("rst_rd_ready", o_rd_req_ready, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        chk("rst_resp_valid", o_rd_resp_valid, 0);
        chkd("rst_resp_data", o_rd_resp_data, '0);
        i_rst_n = 1'b1;
        #1;
        init_boot();

        rd(7'd5, '0);
        rd(7'd127, '0);

        foreach (tbl[i]) begin
            @(negedge i_clk);
            i_clr = 1'b0;
            i_rd_req_valid = tbl[i].rv; i_rd_req_addr = tbl[i].ra; i_rd_resp_ready = tbl[i].rr;
            i_wr_valid = tbl[i].wv; i_wr_addr = tbl[i].wa; i_wr_mask = tbl[i].wm; i_wr_data = mk(tbl[i].ws);
            #1;
            chk($sformatf("v%0d_rd_ready", i), o_rd_req_ready, tbl[i].e_rrdy);
            chk($sformatf("v%0d_wr_ready", i), o_wr_ready, tbl[i].e_wrdy);
            chk($sformatf("v%0d_en", i), o_sram_en, tbl[i].e_en);
            chk($sformatf("v%0d_wmode", i), o_sram_wmode, tbl[i].e_wmode);
            chk($sformatf("v%0d_addr", i), o_sram_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_wmask", i), o_sram_wmask, tbl[i].e_mask);
            chkd($sformatf("v%0d_wdata", i), o_sram_wdata,
                 (tbl[i].e_en && tbl[i].e_wmode) ? mk(tbl[i].ws) : '0);
            chk($sformatf("v%0d_resp_valid", i), o_rd_resp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) chkd($sformatf("v%0d_resp_data", i), o_rd_resp_data, tbl[i].e_d);
        end

        // Read in flight across a clr: old data still delivered, then full re-init
        @(negedge i_clk); idle_in();
        i_wr_valid = 1'b1; i_wr_addr = 7'd9; i_wr_mask = 4'hF; i_wr_data = mk(32'hAAAAAAAA); #1;
        chk("clr_pre_wr_ready", o_wr_ready, 1);
        @(negedge i_clk); idle_in(); i_rd_req_valid = 1'b1; i_rd_req_addr = 7'd9; #1;
        chk("clr_pre_rd_ready", o_rd_req_ready, 1);
        @(negedge i_clk); idle_in(); i_clr = 1'b1; i_wr_valid = 1'b1; i_wr_addr = 7'd9;
        i_wr_mask = 4'hF; i_wr_data = '1; #1;
        chk("clr_wr_ready", o_wr_ready, 0);
        chk("clr_rd_ready", o_rd_req_ready, 0);
        chk("clr_no_grant", o_sram_en, 0);
        chk("clr_init_done", o_init_done, 1);
        init_run(1'b1, mk(32'hAAAAAAAA));
        rd(7'd9, '0);

        // Reset pulse in the middle of INIT restarts the whole fill
        @(negedge i_clk); idle_in(); i_clr = 1'b1;
        for (int k = 0; k <= 60; k++) begin @(negedge i_clk); idle_in(); end
        #1;
        chk("pre_rst_addr", o_sram_addr, 60);
        i_rst_n = 1'b0; #1;
        chk("midrst_en", o_sram_en, 0);
        chk("midrst_addr", o_sram_addr, 0);
        chk("midrst_init_done", o_init_done, 0);
        chk("midrst_wr_ready", o_wr_ready, 0);
        chk("midrst_resp_valid", o_rd_resp_valid, 0);
        @(negedge i_clk); i_rst_n = 1'b1; #1;
        init_boot();
        rd(7'd60, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
